// File: rtl/xdma_to_remote_arb.sv
// xdma_to_remote_arb
// Arbitrates beats from up to four to-remote sources (Finish=0, Grant=1,
// Cfg=2, Data=3) onto a single registered output channel.  Fixed priority
// with the lowest index winning, a lock that keeps a multi-beat burst
// contiguous until its last beat, and a starvation counter that force-grants
// Data after MaxWait lost arbitrations.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   inp_data_i             NumInp x DataWidth per-source payload (source i at
//                          bits [i*DataWidth +: DataWidth])
//   inp_last_i/valid_i     per-source last flag / valid
//   inp_ready_o            per-source accept (at most one bit high)
//   oup_data/idx/last_o    registered granted beat, its source and last flag
//   oup_valid_o/ready_i    output handshake
//   busy_o                 burst in progress or output beat held
module xdma_to_remote_arb #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 512,
  parameter int unsigned MaxWait   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumInp*DataWidth-1:0]   inp_data_i,
  input  logic [NumInp-1:0]             inp_last_i,
  input  logic [NumInp-1:0]             inp_valid_i,
  output logic [NumInp-1:0]             inp_ready_o,
  output logic [DataWidth-1:0]          oup_data_o,
  output logic [1:0]                    oup_idx_o,
  output logic                          oup_last_o,
  output logic                          oup_valid_o,
  input  logic                          oup_ready_i,
  output logic                          busy_o
);

  localparam int unsigned    WaitW   = $clog2(MaxWait + 1);
  localparam logic [1:0]     DataIdx = 2'd3;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

  typedef enum logic {Idle = 1'b0, Locked = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             lock_idx_q, lock_idx_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic                   oup_valid_q, oup_last_q;
  logic [1:0]             oup_idx_q;
  logic [DataWidth-1:0]   oup_data_q;

  logic [3:0]             valid4_s, last4_s, ready4_s;
  logic                   accept_s, gnt_valid_s, gnt_last_s, xfer_s;
  logic [1:0]             gnt_idx_s;
  logic [DataWidth-1:0]   gnt_data_s;

  // Widen per-source flags to four entries; unused sources read as idle so
  // they can never be granted.
  always_comb begin
    valid4_s = 4'b0000;
    last4_s  = 4'b0000;
    for (int i = 0; i < int'(NumInp); i++) begin
      valid4_s[i] = inp_valid_i[i];
      last4_s[i]  = inp_last_i[i];
    end
  end

  // Grant selection: locked source only, else starved Data, else lowest index.
  always_comb begin
    gnt_idx_s   = 2'd0;
    gnt_valid_s = 1'b0;
    if (state_q == Locked) begin
      gnt_idx_s   = lock_idx_q;
      gnt_valid_s = valid4_s[lock_idx_q];
    end else if ((wait_q == WaitMax) && valid4_s[DataIdx]) begin
      gnt_idx_s   = DataIdx;
      gnt_valid_s = 1'b1;
    end else begin
      casez (valid4_s)
        4'b???1: begin gnt_idx_s = 2'd0; gnt_valid_s = 1'b1; end
        4'b??10: begin gnt_idx_s = 2'd1; gnt_valid_s = 1'b1; end
        4'b?100: begin gnt_idx_s = 2'd2; gnt_valid_s = 1'b1; end
        4'b1000: begin gnt_idx_s = 2'd3; gnt_valid_s = 1'b1; end
        default: begin gnt_idx_s = 2'd0; gnt_valid_s = 1'b0; end
      endcase
    end
  end

  // Payload multiplexer for the granted source.
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < int'(NumInp); i++) begin
      if (gnt_idx_s == 2'(i)) begin
        gnt_data_s = inp_data_i[i*DataWidth +: DataWidth];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  assign gnt_last_s = last4_s[gnt_idx_s];
  // Output slot can take a beat when empty or being drained this cycle.
  assign accept_s   = !oup_valid_q || oup_ready_i;
  assign xfer_s     = accept_s && gnt_valid_s;
  assign ready4_s   = (xfer_s && !rst_i) ? (4'b0001 << gnt_idx_s) : 4'b0000;
  assign inp_ready_o = ready4_s[NumInp-1:0];

  // Next-state for lock FSM and Data starvation counter.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    wait_d     = wait_q;
    if (!valid4_s[DataIdx] || (xfer_s && (gnt_idx_s == DataIdx))) begin
      wait_d = '0;
    end else if ((state_q == Idle) && xfer_s && (wait_q != WaitMax)) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end
    case (state_q)
      Idle: begin
        if (xfer_s && !gnt_last_s) begin
          state_d    = Locked;
          lock_idx_d = gnt_idx_s;
        end else begin
          state_d = Idle;
        end
      end
      Locked: begin
        if (xfer_s && gnt_last_s) begin
          state_d = Idle;
        end else begin
          state_d = Locked;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      lock_idx_q <= 2'd0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      wait_q     <= wait_d;
    end
  end

  // Output register slice; holds its beat while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oup_valid_q <= 1'b0;
      oup_last_q  <= 1'b0;
      oup_idx_q   <= 2'd0;
      oup_data_q  <= '0;
    end else if (accept_s) begin
      oup_valid_q <= xfer_s;
      if (xfer_s) begin
        oup_last_q <= gnt_last_s;
        oup_idx_q  <= gnt_idx_s;
        oup_data_q <= gnt_data_s;
      end
    end
  end

  assign oup_valid_o = oup_valid_q;
  assign oup_last_o  = oup_last_q;
  assign oup_idx_o   = oup_idx_q;
  assign oup_data_o  = oup_data_q;
  assign busy_o      = (state_q == Locked) || oup_valid_q;

endmodule

// File: tb/tb_xdma_to_remote_arb.sv
// Testbench for xdma_to_remote_arb: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_xdma_to_remote_arb;
  localparam int NI = 4;
  localparam int DW = 32;
  localparam int MW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI*DW-1:0] inp_data;
  logic [NI-1:0]   inp_last, inp_valid, inp_ready;
  logic [DW-1:0]   oup_data;
  logic [1:0]      oup_idx;
  logic            oup_last, oup_valid, oup_ready, busy;

  xdma_to_remote_arb #(.NumInp(NI), .DataWidth(DW), .MaxWait(MW)) dut (
    .clk_i(clk), .rst_i(rst), .inp_data_i(inp_data), .inp_last_i(inp_last),
    .inp_valid_i(inp_valid), .inp_ready_o(inp_ready), .oup_data_o(oup_data),
    .oup_idx_o(oup_idx), .oup_last_o(oup_last), .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready), .busy_o(busy));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Source-side stimulus: per-source queue of pending beats (their last flags).
  bit          lastq[4][$];
  int          seqn[4];
  logic [3:0]  en;
  bit          rdy;
  logic [3:0]  s_ready;

  // Behavioural model state.
  bit          m_lock;
  int          m_lidx;
  int          m_wait;
  bit          m_ov, m_ol;
  int          m_oi;
  logic [31:0] m_od;

  // Output scoreboard.
  int          obs_idx[$];
  int          obs_cyc[$];
  logic [31:0] obs_dat[$];
  int          exp_seq[4];
  int          open_idx;
  int          cyc = 0;

  task automatic drive();
    rst = rst;
    for (int i = 0; i < NI; i++) begin
      inp_valid[i] = en[i] && (lastq[i].size() > 0);
      inp_last[i]  = (lastq[i].size() > 0) ? lastq[i][0] : 1'b0;
      inp_data[i*DW +: DW] = {8'(i), 24'(seqn[i])};
    end
    oup_ready = rdy;
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_lidx = 0; m_wait = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_oi = 0; m_od = 32'd0;
  endtask

  // One clock cycle: drive, compare against model, advance model and queues.
  task automatic step(input bit r);
    logic [3:0] v, l, er;
    int g;
    bit acc, xf;
    rst = r;
    drive();
    #3;
    v = inp_valid; l = inp_last; s_ready = inp_ready;
    acc = !m_ov || oup_ready;
    g = -1;
    if (m_lock) begin
      if (v[m_lidx]) g = m_lidx;
    end else if (m_wait == MW && v[3]) begin
      g = 3;
    end else begin
      for (int i = 3; i >= 0; i--) if (v[i]) g = i;
    end
    xf = acc && (g >= 0) && !r;
    er = xf ? 4'(1 << g) : 4'b0000;
    checks++;
    if (inp_ready !== er) begin
      errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, inp_ready, er);
    end
    checks++;
    if ($countones(inp_ready) > 1) begin
      errors++; $display("FAIL ready_onehot cyc=%0d got=%b exp=at most one bit", cyc, inp_ready);
    end
    checks++;
    if (oup_valid !== m_ov) begin
      errors++; $display("FAIL oup_valid cyc=%0d got=%b exp=%b", cyc, oup_valid, m_ov);
    end
    if (m_ov) begin
      checks++;
      if ({oup_idx, oup_last, oup_data} !== {2'(m_oi), m_ol, m_od}) begin
        errors++;
        $display("FAIL oup_beat cyc=%0d got idx=%0d last=%b data=%h exp idx=%0d last=%b data=%h",
                 cyc, oup_idx, oup_last, oup_data, m_oi, m_ol, m_od);
      end
    end
    checks++;
    if (busy !== (m_lock || m_ov)) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_lock || m_ov));
    end
    if (!r && oup_valid === 1'b1 && oup_ready) begin
      obs_idx.push_back(int'(oup_idx));
      obs_cyc.push_back(cyc);
      obs_dat.push_back(oup_data);
      checks++;
      if (open_idx >= 0 && int'(oup_idx) != open_idx) begin
        errors++; $display("FAIL interleave cyc=%0d got idx=%0d exp idx=%0d", cyc, oup_idx, open_idx);
      end
      open_idx = oup_last ? -1 : int'(oup_idx);
      checks++;
      if (int'(oup_data[23:0]) != exp_seq[oup_idx]) begin
        errors++; $display("FAIL order cyc=%0d src=%0d got seq=%0d exp seq=%0d",
                           cyc, oup_idx, oup_data[23:0], exp_seq[oup_idx]);
      end
      exp_seq[oup_idx] = int'(oup_data[23:0]) + 1;
    end
    if (r) begin
      model_reset();
    end else begin
      if (!v[3] || (xf && g == 3)) m_wait = 0;
      else if (!m_lock && xf) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      if (xf) begin
        if (!m_lock && !l[g]) begin m_lock = 1'b1; m_lidx = g; end
        else if (m_lock && l[g]) m_lock = 1'b0;
      end
      if (acc) begin
        m_ov = xf;
        if (xf) begin m_oi = g; m_ol = l[g]; m_od = inp_data[g*DW +: DW]; end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      for (int i = 0; i < NI; i++) begin
        if (s_ready[i] && v[i]) begin
          void'(lastq[i].pop_front());
          seqn[i]++;
        end
      end
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NI; i++) begin
      lastq[i].delete(); seqn[i] = 0; exp_seq[i] = 0;
    end
    en = 4'b1111; rdy = 1'b1; open_idx = -1;
  endtask

  task automatic do_reset();
    clear_stim();
    step(1'b1);
    obs_idx.delete(); obs_cyc.delete(); obs_dat.delete();
  endtask

  task automatic test_reset();
    clear_stim();
    for (int i = 0; i < NI; i++) lastq[i].push_back(1'b1);
    step(1'b1);
    checks++;
    if ({oup_valid, oup_last, oup_idx, oup_data, busy} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b l=%b i=%0d d=%h busy=%b exp all 0",
                         oup_valid, oup_last, oup_idx, oup_data, busy);
    end
    do_reset();
  endtask

  task automatic test_priority();
    int c0;
    do_reset();
    lastq[0].push_back(1'b1); lastq[1].push_back(1'b1); lastq[3].push_back(1'b1);
    c0 = cyc;
    repeat (5) step(1'b0);
    checks++;
    if (obs_idx.size() != 3 || obs_idx[0] != 0 || obs_idx[1] != 1 || obs_idx[2] != 3 ||
        obs_cyc[0] != c0 + 1 || obs_cyc[2] != c0 + 3) begin
      errors++; $display("FAIL priority got n=%0d idx=%p cyc=%p exp idx 0,1,3 from cycle %0d",
                         obs_idx.size(), obs_idx, obs_cyc, c0 + 1);
    end
  endtask

  task automatic test_lock();
    bit pend;
    do_reset();
    lastq[3] = '{1'b0, 1'b0, 1'b0, 1'b1};
    step(1'b0);
    lastq[0].push_back(1'b1);
    for (int k = 0; k < 6; k++) begin
      pend = lastq[3].size() > 0;
      step(1'b0);
      if (pend) begin
        checks++;
        if (s_ready[0] !== 1'b0) begin
          errors++; $display("FAIL lock_ready0 cyc=%0d got=%b exp=0", cyc, s_ready[0]);
        end
      end
    end
    checks++;
    if (obs_idx.size() != 5 || obs_idx[0] != 3 || obs_idx[3] != 3 || obs_idx[4] != 0) begin
      errors++; $display("FAIL lock_order got=%p exp 3,3,3,3,0", obs_idx);
    end
  endtask

  task automatic test_starve();
    do_reset();
    repeat (12) begin lastq[0].push_back(1'b1); lastq[3].push_back(1'b1); end
    repeat (8) step(1'b0);
    checks++;
    if (obs_idx.size() < 6 || obs_idx[0] != 0 || obs_idx[1] != 0 || obs_idx[2] != 3 ||
        obs_idx[3] != 0 || obs_idx[4] != 0 || obs_idx[5] != 3) begin
      errors++; $display("FAIL starve got=%p exp 0,0,3,0,0,3", obs_idx);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (4) lastq[1].push_back(1'b1);
    repeat (6) step(1'b0);
    checks++;
    if (obs_idx.size() != 4 || obs_cyc[3] - obs_cyc[0] != 3) begin
      errors++; $display("FAIL back_to_back got n=%0d cyc=%p exp 4 beats on consecutive cycles",
                         obs_idx.size(), obs_cyc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d0;
    do_reset();
    lastq[2] = '{1'b1, 1'b1};
    step(1'b0);
    rdy = 1'b0;
    d0 = oup_data;
    repeat (3) begin
      step(1'b0);
      checks++;
      if (s_ready !== 4'b0000 || oup_data !== d0) begin
        errors++; $display("FAIL stall got ready=%b data=%h exp ready=0000 data=%h", s_ready, oup_data, d0);
      end
    end
    rdy = 1'b1;
    repeat (3) step(1'b0);
    checks++;
    if (obs_idx.size() != 2 || obs_dat[0] !== 32'h0200_0000 || obs_dat[1] !== 32'h0200_0001) begin
      errors++; $display("FAIL stall_resume got n=%0d dat=%p exp 02000000,02000001", obs_idx.size(), obs_dat);
    end
  endtask

  task automatic test_reset_burst();
    do_reset();
    lastq[2] = '{1'b0, 1'b0, 1'b1};
    step(1'b0);
    step(1'b1);
    checks++;
    if (oup_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_burst got valid=%b busy=%b exp 0,0", oup_valid, busy);
    end
    lastq[2].delete();
    lastq[1].push_back(1'b1);
    step(1'b0);
    checks++;
    if (s_ready !== 4'b0010) begin
      errors++; $display("FAIL reset_regrant got=%b exp=0010", s_ready);
    end
    step(1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (lastq[i].size() < 2 && $urandom_range(3, 0) == 0) begin
          int len = $urandom_range(4, 1);
          for (int b = 1; b <= len; b++) lastq[i].push_back(b == len);
        end
      end
      en  = 4'($urandom);
      rdy = ($urandom_range(3, 0) != 0);
      step(1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_stim();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_priority();
    test_lock();
    test_starve();
    test_back_to_back();
    test_stall();
    test_reset_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xdma_to_remote_arb.md
XDMA_TO_REMOTE_ARB -- requirements
Module: xdma_to_remote_arb

Interface
REQ-001 SHALL have parameter NumInp, default 4, number of to-remote sources indexed per xdma_to_remote_idx_e (Finish=0, Grant=1, Cfg=2, Data=3).
REQ-002 SHALL have parameter DataWidth, default 512, beat payload width (AxiDataWidth).
REQ-003 SHALL have parameter MaxWait, default 8, consecutive lost arbitrations after which Data is force-granted; legal range 1..255.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port inp_data_i  input  NumInp x DataWidth  per-source beat payload.
REQ-007 SHALL have port inp_last_i  input  NumInp  per-source last beat of a frame or burst.
REQ-008 SHALL have port inp_valid_i  input  NumInp  per-source beat valid.
REQ-009 SHALL have port inp_ready_o  output  NumInp  per-source beat accepted.
REQ-010 SHALL have port oup_data_o  output  DataWidth  granted beat payload.
REQ-011 SHALL have port oup_idx_o  output  2 (xdma_req_idx_t)  source index of the beat.
REQ-012 SHALL have port oup_last_o  output  1  last flag of the beat.
REQ-013 SHALL have port oup_valid_o  output  1  output beat valid.
REQ-014 SHALL have port oup_ready_i  input  1  downstream accepts beat.
REQ-015 SHALL have port busy_o  output  1  high while in LOCKED or oup_valid_o high.

Function
REQ-016 Output SHALL be a one-entry register slice: slot free when oup_valid_o=0 or oup_ready_i=1 ("accept cycle").
REQ-017 inp_ready_o[i] SHALL be 1 only for the single granted source and only in an accept cycle; at most one bit high.
REQ-018 A beat SHALL transfer on inp_valid_i[i] & inp_ready_o[i] and appear on the outputs exactly 1 cycle later with its data, idx=i, last unchanged.
REQ-019 oup_valid_o SHALL clear one cycle after an output handshake with no new input transfer; output data SHALL hold stable while oup_valid_o=1 and oup_ready_i=0.
REQ-020 FSM states SHALL be IDLE and LOCKED.
REQ-021 In IDLE, grant SHALL go to the lowest-index valid source (Finish > Grant > Cfg > Data), except per REQ-024.
REQ-022 IDLE->LOCKED when a transferred beat has last=0; locked index recorded; LOCKED->IDLE when the locked source's beat with last=1 transfers.
REQ-023 In LOCKED, only the locked source SHALL be granted; other sources SHALL see ready=0 regardless of priority.
REQ-024 Wait counter, $clog2(MaxWait+1) bits, reset 0: in an IDLE accept cycle with Data valid and another source transferring, +1 saturating at MaxWait; when Data transfers or Data is not valid, cleared to 0; otherwise held. When counter == MaxWait in IDLE, Data SHALL be granted over all others.
REQ-025 Beat with last=1 transferred from IDLE SHALL remain in IDLE (single-beat frame).
REQ-026 Simultaneous output handshake and new input transfer in the same cycle SHALL load the new beat with no bubble (full throughput, 1 beat/cycle).
REQ-027 Dropping inp_valid_i of the locked source mid-burst SHALL leave the FSM in LOCKED with no other source granted.
REQ-028 Source index NumInp..3 unused when NumInp<4 SHALL never appear on oup_idx_o.

Reset
REQ-029 While rst_i=1 at a clock edge: state=IDLE, wait counter=0, locked index=0, oup_valid_o=0, oup_last_o=0, oup_idx_o=0, oup_data_o=0.
REQ-030 inp_ready_o SHALL be all-zero during any cycle where rst_i=1; busy_o=0 the cycle after reset.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; after release the arbiter SHALL arbitrate fresh from IDLE.

Verification
REQ-032 Finish, Grant, Data all valid with last=1, oup_ready_i=1 -> oup_idx_o sequence 0,1,3 on consecutive cycles starting 1 cycle after first valid.
REQ-033 Data 4-beat burst (last on beat 4) started, Finish asserts after beat 1 -> oup_idx_o 3,3,3,3 then 0; inp_ready_o[0]=0 during burst.
REQ-034 MaxWait=2, Finish valid continuously with last=1, Data valid -> idx sequence 0,0,3,0,0,3...
REQ-035 oup_ready_i=0 for 3 cycles with Cfg beat pending -> oup_data_o stable, inp_ready_o all 0 for those cycles, then transfer resumes without loss or duplication.
REQ-036 rst_i pulsed for 1 cycle during beat 2 of a Cfg 3-frame transfer -> oup_valid_o=0 next cycle, state IDLE, a subsequent Grant beat is granted immediately.
REQ-037 Random valid/ready/last stimulus for 10000 cycles -> scoreboard shows per-source order preserved, no interleaving inside last-delimited bursts, at most one inp_ready_o bit high.
